// File: rtl/game_pkg.sv
// Shared definitions for the number game: state encoding and the default
// target range / spin / retry constants used by the generator and controller.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEFAULT_N         = 8;
    localparam int DEFAULT_MAX_VAL   = 99;
    localparam int DEFAULT_MIN_SPIN  = 3;
    localparam int DEFAULT_MAX_TRIES = 16;

endpackage

// File: rtl/game_target_gen_if.sv
// Bundle between the target generator, the game LFSR and the game controller.
// master is the generator side; slave is the LFSR/controller side.
interface game_target_gen_if
    import game_pkg::*;
#(
    parameter int N = DEFAULT_N
);
    logic [N-1:0] lfsr_q;
    logic         lfsr_en;
    logic         req;
    logic         target_ack;
    logic [N-1:0] target;
    logic         target_valid;
    logic         fallback;
    logic         busy;

    modport master (
        input  lfsr_q, req, target_ack,
        output lfsr_en, target, target_valid, fallback, busy
    );

    modport slave (
        output lfsr_q, req, target_ack,
        input  lfsr_en, target, target_valid, fallback, busy
    );
endinterface

// File: rtl/game_target_gen.sv
// Random target generator: spins the LFSR, filters out-of-range and repeated
// values, and falls back to prev+1 after a bounded number of rejections.
module game_target_gen
    import game_pkg::*;
#(
    parameter int N         = DEFAULT_N,
    parameter int MAX_VAL   = DEFAULT_MAX_VAL,
    parameter int MIN_SPIN  = DEFAULT_MIN_SPIN,
    parameter int MAX_TRIES = DEFAULT_MAX_TRIES
) (
    input logic              clk,
    input logic              reset,
    game_target_gen_if.master bus
);

    localparam int SPIN_W = $clog2(MIN_SPIN) + 1;
    localparam int TRY_W  = $clog2(MAX_TRIES) + 1;

    localparam logic [SPIN_W-1:0] SPIN_LIMIT = SPIN_W'(MIN_SPIN);
    localparam logic [TRY_W-1:0]  TRY_LAST   = TRY_W'(MAX_TRIES - 1);
    localparam logic [N-1:0]      MAX_VAL_N  = N'(MAX_VAL);
    localparam logic [N-1:0]      ONE_N      = N'(1);

    state_t            state;
    state_t            state_next;
    logic [SPIN_W-1:0] spin_cnt;
    logic [TRY_W-1:0]  try_cnt;
    logic [N-1:0]      prev;
    logic [N-1:0]      target_r;
    logic              fallback_r;

    logic              spin_done;
    logic              evaluate;
    logic              accept;
    logic              last_try;
    logic [N-1:0]      fallback_val;

    logic              lfsr_en_c;
    logic              busy_c;
    logic              valid_c;

    // The round ends in the cycle that either accepts a value or records the last allowed rejection.
    always_comb begin
        spin_done    = (spin_cnt == SPIN_LIMIT);
        evaluate     = (state == SPIN) && spin_done;
        accept       = (bus.lfsr_q != '0) && (bus.lfsr_q <= MAX_VAL_N) && (bus.lfsr_q != prev);
        last_try     = (try_cnt == TRY_LAST);
        fallback_val = ((prev == MAX_VAL_N) || (prev == '0)) ? ONE_N : (prev + ONE_N);
    end

    // State register; reset drops straight back to IDLE so the LFSR stops immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; req is only honoured in IDLE and ack only in HOLD.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.req) state_next = SPIN;
            SPIN: if (evaluate && (accept || last_try)) state_next = HOLD;
            HOLD: if (bus.target_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs depend on the state register alone, never on inputs.
    always_comb begin
        lfsr_en_c = (state == SPIN);
        busy_c    = (state == SPIN) || (state == HOLD);
        valid_c   = (state == HOLD);
    end

    // Counters and the accepted target; target/prev/fallback only change when a round resolves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spin_cnt   <= '0;
            try_cnt    <= '0;
            prev       <= '0;
            target_r   <= '0;
            fallback_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    spin_cnt <= '0;
                    try_cnt  <= '0;
                end
                SPIN: begin
                    if (!spin_done) begin
                        spin_cnt <= spin_cnt + SPIN_W'(1);
                    end else if (accept) begin
                        target_r   <= bus.lfsr_q;
                        prev       <= bus.lfsr_q;
                        fallback_r <= 1'b0;
                    end else if (last_try) begin
                        target_r   <= fallback_val;
                        prev       <= fallback_val;
                        fallback_r <= 1'b1;
                    end else begin
                        try_cnt <= try_cnt + TRY_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.lfsr_en      = lfsr_en_c;
    assign bus.busy         = busy_c;
    assign bus.target_valid = valid_c;
    assign bus.target       = target_r;
    assign bus.fallback     = fallback_r;

endmodule
